// File: rtl/wc_line_engine.sv
// Line fill / write-back engine for the write-back cache: reads the victim tag,
// bursts a dirty victim line to PSRAM, refills the line and writes the new tag.
module wc_line_engine #(
    parameter int IDX_W = 4,
    parameter int WRD_W = 4,
    parameter int TAG_W = 13
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [IDX_W-1:0]                 req_index,
    input  logic [TAG_W-1:0]                 req_tag,
    output logic                             done,
    output logic                             busy,
    output logic                             tag_en,
    output logic                             tag_we,
    output logic [IDX_W-1:0]                 tag_addr,
    output logic [TAG_W+1:0]                 tag_din,
    input  logic [TAG_W+1:0]                 tag_dout,
    output logic                             dat_en,
    output logic [3:0]                       dat_we,
    output logic [IDX_W+WRD_W-1:0]           dat_addr,
    output logic [31:0]                      dat_din,
    input  logic [31:0]                      dat_dout,
    output logic                             ps_cmd_valid,
    input  logic                             ps_cmd_ready,
    output logic                             ps_cmd_write,
    output logic [TAG_W+IDX_W+WRD_W+1:0]     ps_cmd_addr,
    output logic [31:0]                      ps_wdata,
    output logic                             ps_wvalid,
    input  logic                             ps_wready,
    input  logic [31:0]                      ps_rdata,
    input  logic                             ps_rvalid
);

    localparam logic [WRD_W+1:0] LINE_OFS = '0;
    localparam logic [WRD_W-1:0] LAST_WRD = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TAG_RD,
        S_TAG_CHK,
        S_WB_CMD,
        S_WB_DATA,
        S_FILL_CMD,
        S_FILL_DATA,
        S_TAG_WR,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   victim_tag;
    logic [WRD_W-1:0]   cnt;
    logic [WRD_W-1:0]   beat;
    logic               rd_all;
    logic               rd_pend;
    logic               buf_full;
    logic [31:0]        buf_data;
    logic               rd_issue;
    logic               beat_take;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx_q      <= '0;
            tag_q      <= '0;
            victim_tag <= '0;
            cnt        <= '0;
            beat       <= '0;
            rd_all     <= 1'b0;
            rd_pend    <= 1'b0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        idx_q <= req_index;
                        tag_q <= req_tag;
                    end
                end
                S_TAG_CHK: begin
                    victim_tag <= tag_dout[TAG_W-1:0];
                    cnt        <= '0;
                    beat       <= '0;
                    rd_all     <= 1'b0;
                    rd_pend    <= 1'b0;
                    buf_full   <= 1'b0;
                end
                S_WB_DATA: begin
                    // A read issued last cycle lands in the buffer now; the issue
                    // rule guarantees the buffer is empty or draining at that point.
                    rd_pend <= rd_issue;
                    if (rd_issue) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_WRD) rd_all <= 1'b1;
                    end
                    if (beat_take) beat <= beat + 1'b1;
                    if (rd_pend) begin
                        buf_data <= dat_dout;
                        buf_full <= 1'b1;
                    end else if (beat_take) begin
                        buf_full <= 1'b0;
                    end
                end
                S_FILL_CMD:  cnt <= '0;
                S_FILL_DATA: if (ps_rvalid) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        done         = 1'b0;
        busy         = (state != S_IDLE);
        tag_en       = 1'b0;
        tag_we       = 1'b0;
        tag_addr     = '0;
        tag_din      = '0;
        dat_en       = 1'b0;
        dat_we       = 4'h0;
        dat_addr     = '0;
        dat_din      = '0;
        ps_cmd_valid = 1'b0;
        ps_cmd_write = 1'b0;
        ps_cmd_addr  = '0;
        ps_wdata     = buf_data;
        ps_wvalid    = 1'b0;
        rd_issue     = 1'b0;
        beat_take    = 1'b0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_TAG_RD;
            end
            S_TAG_RD: begin
                tag_en    = 1'b1;
                tag_addr  = idx_q;
                state_nxt = S_TAG_CHK;
            end
            S_TAG_CHK: begin
                if (tag_dout[TAG_W+1] && tag_dout[TAG_W]) state_nxt = S_WB_CMD;
                else                                       state_nxt = S_FILL_CMD;
            end
            S_WB_CMD: begin
                ps_cmd_valid = 1'b1;
                ps_cmd_write = 1'b1;
                ps_cmd_addr  = {victim_tag, idx_q, LINE_OFS};
                if (ps_cmd_ready) state_nxt = S_WB_DATA;
            end
            S_WB_DATA: begin
                ps_wvalid = buf_full;
                beat_take = buf_full && ps_wready;
                rd_issue  = !rd_all && !rd_pend && (!buf_full || beat_take);
                dat_en    = rd_issue;
                dat_addr  = {idx_q, cnt};
                if (beat_take && beat == LAST_WRD) state_nxt = S_FILL_CMD;
            end
            S_FILL_CMD: begin
                ps_cmd_valid = 1'b1;
                ps_cmd_addr  = {tag_q, idx_q, LINE_OFS};
                if (ps_cmd_ready) state_nxt = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                dat_en   = ps_rvalid;
                dat_we   = {4{ps_rvalid}};
                dat_addr = {idx_q, cnt};
                dat_din  = ps_rdata;
                if (ps_rvalid && cnt == LAST_WRD) state_nxt = S_TAG_WR;
            end
            S_TAG_WR: begin
                tag_en    = 1'b1;
                tag_we    = 1'b1;
                tag_addr  = idx_q;
                tag_din   = {1'b0, 1'b1, tag_q};
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
